fp_norm_seq: RTL and testbench

FP_NORM_SEQ -- requirements
Module: fp_norm_seq

---
 rtl/fp_pkg.sv | 29 ++
 rtl/fp_norm_seq.sv | 137 +++++++++++++
 tb/tb_fp_norm_seq.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// ============================================================================
// Package     : fp_pkg
// Description : Shared floating-point definitions for the add/sub datapath
//               and the post-normalization sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_pkg;

    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    // Bit positions inside the 3-bit {overflow, underflow, zero} flag word
    localparam int FLAG_ZERO      = 0;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_OVERFLOW  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : fp_pkg

`default_nettype wire

// File: rtl/fp_norm_seq.sv
// ============================================================================
// Module      : fp_norm_seq
// Description : Iterative normalizer/packer for raw add/sub results. Takes a
//               sign, pre-normalization exponent and raw (carry+hidden+frac)
//               mantissa, normalizes with at most one shift per cycle and
//               emits a packed IEEE-754 single plus status flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_norm_seq
    import fp_pkg::*;
#(
    parameter int EXP_W  = fp_pkg::EXP_W,
    parameter int FRAC_W = fp_pkg::FRAC_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_sign,
    input  logic [EXP_W-1:0]         in_exp,
    input  logic [FRAC_W+1:0]        in_mant,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+FRAC_W:0]    out_y,
    output logic [2:0]               out_flags
);

    // Exponent is carried one bit wider so increments/decrements never wrap
    localparam logic [EXP_W:0] c_EXP_ONE = {{EXP_W{1'b0}}, 1'b1};
    localparam logic [EXP_W:0] c_EXP_TOP = {1'b0, {EXP_W{1'b1}}};

    state_t                  r_state, w_state_nxt;
    logic                    r_sign,  w_sign_nxt;
    logic [EXP_W:0]          r_exp,   w_exp_nxt;
    logic [FRAC_W+1:0]       r_mant,  w_mant_nxt;
    logic                    r_special, w_special_nxt;
    logic [EXP_W+FRAC_W:0]   r_y,     w_y_nxt;
    logic [2:0]              r_flags, w_flags_nxt;
    logic [EXP_W:0]          w_exp_inc;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out_y     = r_y;
    assign out_flags = r_flags;
    assign w_exp_inc = r_exp + c_EXP_ONE;

    // Next-state and datapath: one normalization decision per NORM cycle
    always_comb begin
        w_state_nxt   = r_state;
        w_sign_nxt    = r_sign;
        w_exp_nxt     = r_exp;
        w_mant_nxt    = r_mant;
        w_special_nxt = r_special;
        w_y_nxt       = r_y;
        w_flags_nxt   = r_flags;

        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_sign_nxt    = in_sign;
                    w_exp_nxt     = {1'b0, in_exp};
                    w_mant_nxt    = in_mant;
                    w_special_nxt = &in_exp;
                    w_state_nxt   = NORM;
                end
            end

            NORM: begin
                w_state_nxt = DONE;
                w_flags_nxt = '0;
                if (r_special) begin
                    // Inf/NaN encodings pass straight through
                    w_y_nxt = {r_sign, r_exp[EXP_W-1:0], r_mant[FRAC_W-1:0]};
                end else if (r_mant == '0) begin
                    w_y_nxt                = '0;
                    w_flags_nxt[FLAG_ZERO] = 1'b1;
                end else if (r_mant[FRAC_W+1]) begin
                    // Carry out: single right shift, LSB dropped (truncation)
                    if (w_exp_inc >= c_EXP_TOP) begin
                        w_y_nxt                    = {r_sign, c_EXP_TOP[EXP_W-1:0], {FRAC_W{1'b0}}};
                        w_flags_nxt[FLAG_OVERFLOW] = 1'b1;
                    end else begin
                        w_y_nxt = {r_sign, w_exp_inc[EXP_W-1:0], r_mant[FRAC_W:1]};
                    end
                end else if (r_mant[FRAC_W]) begin
                    w_y_nxt = {r_sign, r_exp[EXP_W-1:0], r_mant[FRAC_W-1:0]};
                end else if (r_exp <= c_EXP_ONE) begin
                    // No exponent left to borrow from: flush to signed zero
                    w_y_nxt                     = {r_sign, {(EXP_W+FRAC_W){1'b0}}};
                    w_flags_nxt[FLAG_UNDERFLOW] = 1'b1;
                    w_flags_nxt[FLAG_ZERO]      = 1'b1;
                end else begin
                    w_mant_nxt  = {r_mant[FRAC_W:0], 1'b0};
                    w_exp_nxt   = r_exp - c_EXP_ONE;
                    w_flags_nxt = r_flags;
                    w_state_nxt = NORM;
                end
            end

            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_sign    <= 1'b0;
            r_exp     <= '0;
            r_mant    <= '0;
            r_special <= 1'b0;
            r_y       <= '0;
            r_flags   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_sign    <= w_sign_nxt;
            r_exp     <= w_exp_nxt;
            r_mant    <= w_mant_nxt;
            r_special <= w_special_nxt;
            r_y       <= w_y_nxt;
            r_flags   <= w_flags_nxt;
        end
    end

endmodule : fp_norm_seq

`default_nettype wire

// File: tb/tb_fp_norm_seq.sv
// ============================================================================
// Module      : tb_fp_norm_seq
// Description : Directed, table-driven self-checking bench for fp_norm_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_norm_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [24:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_y;
    logic [2:0]  out_flags;

    int n_checks;
    int n_errors;

    fp_norm_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_flags (out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sign;
        logic [7:0]  exp;
        logic [24:0] mant;
        logic [31:0] y;
        logic [2:0]  flags;
        int          edges;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Present one input, count edges (accept edge = 1) until out_valid; leaves DUT in DONE
    task automatic issue(input logic s, input logic [7:0] e, input logic [24:0] m, output int edges);
        @(negedge clk);
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = e;
        in_mant  = m;
        @(posedge clk);
        edges = 1;
        #1;
        in_valid = 1'b0;
        in_mant  = '0;
        while (!out_valid && edges < 60) begin
            @(posedge clk);
            edges++;
            #1;
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int   edges;
        logic [31:0] y_hold;
        logic [2:0]  f_hold;
        logic        bad;

        n_checks  = 0;
        n_errors  = 0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_mant   = '0;
        out_ready = 1'b0;
        rst_n     = 1'b0;

        vecs[0] = '{1'b0, 8'h80, 25'h1800000, 32'h40C00000, 3'b000, 2};
        vecs[1] = '{1'b0, 8'h80, 25'h0200000, 32'h3F000000, 3'b000, 4};
        vecs[2] = '{1'b1, 8'h85, 25'h0000000, 32'h00000000, 3'b001, 2};
        vecs[3] = '{1'b1, 8'h01, 25'h0400000, 32'h80000000, 3'b011, 2};
        vecs[4] = '{1'b0, 8'hFE, 25'h1000000, 32'h7F800000, 3'b100, 2};
        vecs[5] = '{1'b1, 8'h7F, 25'h0800000, 32'hBF800000, 3'b000, 2};
        vecs[6] = '{1'b0, 8'hFF, 25'h0C00001, 32'h7FC00001, 3'b000, 2};
        vecs[7] = '{1'b0, 8'h7F, 25'h1FFFFFF, 32'h407FFFFF, 3'b000, 2};
        vecs[8] = '{1'b0, 8'h03, 25'h0100000, 32'h00000000, 3'b011, 4};
        vecs[9] = '{1'b1, 8'h90, 25'h0000001, 32'hBC800000, 3'b000, 25};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_y", out_y, 32'd0);
        chk("rst_out_flags", {29'b0, out_flags}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Table-driven vectors
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].sign, vecs[i].exp, vecs[i].mant, edges);
            chk($sformatf("v%0d_latency", i), edges, vecs[i].edges);
            chk($sformatf("v%0d_y", i), out_y, vecs[i].y);
            chk($sformatf("v%0d_flags", i), {29'b0, out_flags}, {29'b0, vecs[i].flags});
            release_out();
            chk($sformatf("v%0d_back_idle", i), {31'b0, in_ready}, 32'd1);
        end

        // Back-pressure: hold DONE for 5 cycles with spurious in_valid pulses
        issue(1'b0, 8'h80, 25'h1800000, edges);
        y_hold = out_y;
        f_hold = out_flags;
        bad    = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = c[0];
            in_sign  = 1'b1;
            in_exp   = 8'h10;
            in_mant  = 25'h0000000;
            @(posedge clk);
            #1;
            if (out_y !== y_hold || out_flags !== f_hold || in_ready !== 1'b0 || out_valid !== 1'b1)
                bad = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("hold_stable", {31'b0, bad}, 32'd0);
        chk("hold_y", y_hold, 32'h40C00000);
        release_out();
        chk("hold_release_idle", {31'b0, in_ready}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_no_spurious", {31'b0, out_valid}, 32'd0);

        // Reset during the third NORM cycle of a 10-shift input
        @(negedge clk);
        in_valid = 1'b1;
        in_sign  = 1'b1;
        in_exp   = 8'h90;
        in_mant  = 25'h0002000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_out_y", out_y, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bad   = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) bad = 1'b1;
        end
        chk("midrst_no_output", {31'b0, bad}, 32'd0);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        issue(1'b0, 8'h80, 25'h0200000, edges);
        chk("post_rst_latency", edges, 4);
        chk("post_rst_y", out_y, 32'h3F000000);
        release_out();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fp_norm_seq

`default_nettype wire
